// File: rtl/td4_prog_ram.sv
// Double-buffered 16x8 program memory for the TD4 core: the active bank feeds
// op/im combinationally while a host byte stream reloads the shadow bank.
`timescale 1ns/1ps
module td4_prog_ram #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pc,
  output logic [3:0] op,
  output logic [3:0] im,
  input  logic       load_start,
  input  logic       load_abort,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       cpu_hold,
  output logic       cpu_rst_req,
  output logic       load_ok,
  output logic       load_err,
  output logic       bank
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_mem [2][16];
  logic            r_bank;
  logic [3:0]      r_addr;
  logic [7:0]      r_sum;
  logic [TW-1:0]   r_tcnt;
  logic            r_err;

  logic            w_busy;
  logic            w_xfer;
  logic            w_timeout;
  logic            w_abort;
  logic            w_start;
  logic [7:0]      w_sum_next;

  assign w_busy     = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_xfer     = wr_valid && w_busy;
  assign w_sum_next = r_sum + wr_data;
  assign w_timeout  = w_busy && !w_xfer && (TIMEOUT != 0) &&
                      (r_tcnt == TW'(TIMEOUT - 1));
  // Abort beats a simultaneous byte transfer, so that byte is simply dropped.
  assign w_abort    = w_busy && (load_abort || w_timeout);
  assign w_start    = (r_state == S_IDLE) && load_start;

  assign {op, im}   = r_mem[r_bank][pc];
  assign bank       = r_bank;
  assign load_err   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    wr_ready     = 1'b0;
    cpu_hold     = 1'b0;
    load_ok      = 1'b0;
    cpu_rst_req  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        cpu_hold = 1'b1;
        if (w_abort)                         w_state_next = S_IDLE;
        else if (w_xfer && r_addr == 4'hF)   w_state_next = S_CHECK;
      end
      S_CHECK: begin
        wr_ready = 1'b1;
        cpu_hold = 1'b1;
        if (w_abort)     w_state_next = S_IDLE;
        else if (w_xfer) w_state_next = (w_sum_next == 8'h00) ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: begin
        cpu_hold     = 1'b1;
        load_ok      = 1'b1;
        cpu_rst_req  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank <= 1'b0;
      r_addr <= '0;
      r_sum  <= '0;
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_err  <= 1'b0;
        r_addr <= '0;
        r_sum  <= '0;
        r_tcnt <= '0;
      end else if (w_abort) begin
        r_err <= 1'b1;
      end else if (w_xfer) begin
        r_tcnt <= '0;
        if (r_state == S_LOAD) begin
          r_addr <= r_addr + 4'd1;
          r_sum  <= w_sum_next;
        end else if (w_sum_next != 8'h00) begin
          r_err <= 1'b1;
        end
      end else if (w_busy) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (r_state == S_COMMIT) r_bank <= ~r_bank;
    end
  end

  // NOTE: the banks are flops with a reset (not RAM macros) because the core
  // must come out of reset executing a known all-zero program.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 16; a++)
          r_mem[b][a] <= 8'h00;
    end else if (r_state == S_LOAD && w_xfer && !w_abort) begin
      r_mem[~r_bank][r_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_td4_prog_ram.sv
// Directed testbench for td4_prog_ram: loads, checksum failure, stalls,
// abort, timeout and mid-load reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_td4_prog_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pc;
  logic [3:0] op, im;
  logic       load_start, load_abort, wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready, cpu_hold, cpu_rst_req, load_ok, load_err, bank;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ok     = 0;
  int n_rq     = 0;

  td4_prog_ram #(.TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .pc(pc), .op(op), .im(im),
    .load_start(load_start), .load_abort(load_abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cpu_hold(cpu_hold), .cpu_rst_req(cpu_rst_req), .load_ok(load_ok),
    .load_err(load_err), .bank(bank)
  );

  always #5 clk = ~clk;

  // Pulses are counted on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (load_ok)     n_ok <= n_ok + 1;
    if (cpu_rst_req) n_rq <= n_rq + 1;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: each starts and ends on a falling edge.
  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (bank !== 1'b0)        begin n_fail++; $display("FAIL reset_bank: got %b expected 0", bank); end
    if (cpu_hold !== 1'b0)    begin n_fail++; $display("FAIL reset_hold: got %b expected 0", cpu_hold); end
    if (wr_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_ready: got %b expected 0", wr_ready); end
    if (load_ok !== 1'b0)     begin n_fail++; $display("FAIL reset_ok: got %b expected 0", load_ok); end
    if (cpu_rst_req !== 1'b0) begin n_fail++; $display("FAIL reset_rstreq: got %b expected 0", cpu_rst_req); end
    if (load_err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b expected 0", load_err); end
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      n_checks++;
      if ({op, im} !== 8'h00) begin
        n_fail++; $display("FAIL reset_read pc=%0d: got %h expected 00", i, {op, im});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_good_load();
    int ok0, rq0;
    ok0 = n_ok; rq0 = n_rq;
    start_load();
    n_checks += 2;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL good_ready: got %b expected 1", wr_ready); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL good_hold: got %b expected 1", cpu_hold); end
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    pc = 4'd5;
    #1;
    n_checks += 2;
    if ({op, im} !== 8'h00) begin n_fail++; $display("FAIL good_active_intact: got %h expected 00", {op, im}); end
    if (wr_ready !== 1'b1)  begin n_fail++; $display("FAIL good_check_ready: got %b expected 1", wr_ready); end
    // Byte sum of 0x10..0x1F is 0x78 mod 256; its complement is 0x88.
    send_byte(8'h88);
    n_checks += 4;
    if (load_ok !== 1'b1)     begin n_fail++; $display("FAIL good_commit_ok: got %b expected 1", load_ok); end
    if (cpu_rst_req !== 1'b1) begin n_fail++; $display("FAIL good_commit_rstreq: got %b expected 1", cpu_rst_req); end
    if (bank !== 1'b0)        begin n_fail++; $display("FAIL good_commit_bank: got %b expected 0", bank); end
    if (wr_ready !== 1'b0)    begin n_fail++; $display("FAIL good_commit_ready: got %b expected 0", wr_ready); end
    @(negedge clk);
    n_checks += 6;
    if (bank !== 1'b1)        begin n_fail++; $display("FAIL good_bank: got %b expected 1", bank); end
    if (load_ok !== 1'b0)     begin n_fail++; $display("FAIL good_ok_drop: got %b expected 0", load_ok); end
    if (cpu_hold !== 1'b0)    begin n_fail++; $display("FAIL good_hold_drop: got %b expected 0", cpu_hold); end
    if (n_ok - ok0 !== 1)     begin n_fail++; $display("FAIL good_ok_pulses: got %0d expected 1", n_ok - ok0); end
    if (n_rq - rq0 !== 1)     begin n_fail++; $display("FAIL good_rstreq_pulses: got %0d expected 1", n_rq - rq0); end
    if (op !== 4'h1 || im !== 4'h5) begin
      n_fail++; $display("FAIL good_pc5: got op=%h im=%h expected op=1 im=5", op, im);
    end
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      n_checks++;
      if ({op, im} !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL good_read pc=%0d: got %h expected %h", i, {op, im}, 8'h10 + 8'(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bad_checksum();
    int ok0, rq0;
    ok0 = n_ok; rq0 = n_rq;
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    send_byte(8'h87);
    n_checks += 4;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b expected 1", load_err); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bad_ready: got %b expected 0", wr_ready); end
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL bad_hold: got %b expected 0", cpu_hold); end
    if (bank !== 1'b1)     begin n_fail++; $display("FAIL bad_bank: got %b expected 1", bank); end
    @(negedge clk);
    pc = 4'd5;
    #1;
    n_checks += 3;
    if (n_rq - rq0 !== 0)   begin n_fail++; $display("FAIL bad_rstreq_pulses: got %0d expected 0", n_rq - rq0); end
    if (n_ok - ok0 !== 0)   begin n_fail++; $display("FAIL bad_ok_pulses: got %0d expected 0", n_ok - ok0); end
    if ({op, im} !== 8'h15) begin n_fail++; $display("FAIL bad_pc5: got %h expected 15", {op, im}); end
    @(negedge clk);
  endtask

  task automatic test_stalled_host();
    int ok0;
    ok0 = n_ok;
    start_load();
    n_checks++;
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL stall_err_clear: got %b expected 0", load_err); end
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        idle(1);
      end else begin
        idle(2);
      end
      send_byte(8'h40 + 8'(i));
    end
    idle(2);
    send_byte(8'h88);
    n_checks++;
    if (load_ok !== 1'b1) begin n_fail++; $display("FAIL stall_commit_ok: got %b expected 1", load_ok); end
    @(negedge clk);
    n_checks += 2;
    if (bank !== 1'b0)    begin n_fail++; $display("FAIL stall_bank: got %b expected 0", bank); end
    if (n_ok - ok0 !== 1) begin n_fail++; $display("FAIL stall_ok_pulses: got %0d expected 1", n_ok - ok0); end
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      n_checks++;
      if ({op, im} !== 8'h40 + 8'(i)) begin
        n_fail++; $display("FAIL stall_read pc=%0d: got %h expected %h", i, {op, im}, 8'h40 + 8'(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ok0;
    ok0 = n_ok;
    start_load();
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i));
    wr_valid   = 1'b1;
    wr_data    = 8'h57;
    load_abort = 1'b1;
    @(negedge clk);
    wr_valid   = 1'b0;
    load_abort = 1'b0;
    pc = 4'd3;
    #1;
    n_checks += 6;
    if (load_err !== 1'b1)  begin n_fail++; $display("FAIL abort_err: got %b expected 1", load_err); end
    if (wr_ready !== 1'b0)  begin n_fail++; $display("FAIL abort_ready: got %b expected 0", wr_ready); end
    if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL abort_hold: got %b expected 0", cpu_hold); end
    if (bank !== 1'b0)      begin n_fail++; $display("FAIL abort_bank: got %b expected 0", bank); end
    if ({op, im} !== 8'h43) begin n_fail++; $display("FAIL abort_pc3: got %h expected 43", {op, im}); end
    if (n_ok - ok0 !== 0)   begin n_fail++; $display("FAIL abort_ok_pulses: got %0d expected 0", n_ok - ok0); end
    @(negedge clk);
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    n_checks += 2;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL abort_idle_err: got %b expected 1", load_err); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ready: got %b expected 0", wr_ready); end
    start_load();
    n_checks += 2;
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL abort_restart_err: got %b expected 0", load_err); end
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_restart_ready: got %b expected 1", wr_ready); end
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    n_checks++;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL abort_second_err: got %b expected 1", load_err); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    start_load();
    for (int i = 0; i < 3; i++) send_byte(8'h70 + 8'(i));
    idle(9);
    n_checks += 2;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL timeout_early_hold: got %b expected 1", cpu_hold); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early_err: got %b expected 0", load_err); end
    idle(2);
    pc = 4'd7;
    #1;
    n_checks += 5;
    if (load_err !== 1'b1)  begin n_fail++; $display("FAIL timeout_err: got %b expected 1", load_err); end
    if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL timeout_hold: got %b expected 0", cpu_hold); end
    if (wr_ready !== 1'b0)  begin n_fail++; $display("FAIL timeout_ready: got %b expected 0", wr_ready); end
    if (bank !== 1'b0)      begin n_fail++; $display("FAIL timeout_bank: got %b expected 0", bank); end
    if ({op, im} !== 8'h47) begin n_fail++; $display("FAIL timeout_pc7: got %h expected 47", {op, im}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
    send_byte(8'h88);
    @(negedge clk);
    n_checks++;
    if (bank !== 1'b1) begin n_fail++; $display("FAIL rml_pre_bank: got %b expected 1", bank); end
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (bank !== 1'b0)     begin n_fail++; $display("FAIL rml_bank: got %b expected 0", bank); end
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rml_hold: got %b expected 0", cpu_hold); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rml_ready: got %b expected 0", wr_ready); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL rml_err: got %b expected 0", load_err); end
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      n_checks++;
      if ({op, im} !== 8'h00) begin
        n_fail++; $display("FAIL rml_read pc=%0d: got %h expected 00", i, {op, im});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rml_post_ready: got %b expected 0", wr_ready); end
    if (bank !== 1'b0)     begin n_fail++; $display("FAIL rml_post_bank: got %b expected 0", bank); end
  endtask

  initial begin
    rst        = 1'b0;
    pc         = 4'd0;
    load_start = 1'b0;
    load_abort = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_stalled_host();
    test_abort();
    test_timeout();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
